// File: rtl/crc_stream_checker.sv
// crc_stream_checker: receive-side CRC checker. Folds payload words into a running
// CRC (CRC-32 0x04C11DB7 or CRC-16 0x8005, MSB-first, one word per step), compares the
// trailing CRC word against the result and flags early or missing end-of-frame markers.
module crc_stream_checker #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      init,
  input  logic [3:0]       select,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             done,
  output logic             pass,
  output logic             err_len,
  output logic [31:0]      crc_calc
);

  localparam int unsigned CRC32_W   = 32;
  localparam int unsigned CRC16_W   = 16;
  localparam logic [CRC32_W-1:0] POLY32 = 32'h04C1_1DB7;
  localparam logic [CRC16_W-1:0] POLY16 = 16'h8005;
  localparam logic [3:0]   SEL_CRC32 = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One 32-bit step of the CRC-32 LFSR applied to an already-combined state^data word.
  function automatic logic [CRC32_W-1:0] step32(input logic [CRC32_W-1:0] x);
    logic [CRC32_W-1:0] c;
    c = x;
    for (int i = 0; i < int'(CRC32_W); i++) begin
      c = c[CRC32_W-1] ? ((c << 1) ^ POLY32) : (c << 1);
    end
    return c;
  endfunction

  // One 16-bit step of the CRC-16 LFSR applied to an already-combined state^data half-word.
  function automatic logic [CRC16_W-1:0] step16(input logic [CRC16_W-1:0] x);
    logic [CRC16_W-1:0] c;
    c = x;
    for (int i = 0; i < int'(CRC16_W); i++) begin
      c = c[CRC16_W-1] ? ((c << 1) ^ POLY16) : (c << 1);
    end
    return c;
  endfunction

  // Mode-dependent CRC update; the 16-bit result is zero-extended so the upper half stays clear.
  function automatic logic [CRC32_W-1:0] crc_step(input logic             mode32,
                                                  input logic [CRC32_W-1:0] s,
                                                  input logic [CRC32_W-1:0] d);
    logic [CRC32_W-1:0] r;
    if (mode32) begin
      r = step32(s ^ d);
    end else begin
      r = {16'h0000, step16(s[CRC16_W-1:0] ^ d[CRC16_W-1:0])};
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [CRC32_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode32_q, mode32_d;
  logic               pass_d;
  logic               err_len_d;
  logic [CRC32_W-1:0] crc_calc_d;

  logic               hs_c;
  logic               match_c;
  logic [CRC32_W-1:0] crc_masked_c;
  logic               crc_beat_c;

  // Handshake and CRC-beat comparison terms used by the next-state logic.
  always_comb begin
    hs_c         = s_valid && s_ready;
    crc_beat_c   = (cnt_q == len_q);
    crc_masked_c = mode32_q ? crc_q : {16'h0000, crc_q[CRC16_W-1:0]};
    match_c      = mode32_q ? (s_data == crc_q)
                            : (s_data[CRC16_W-1:0] == crc_q[CRC16_W-1:0]);
  end

  // State register plus all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      crc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      mode32_q <= 1'b0;
      pass     <= 1'b0;
      err_len  <= 1'b0;
      crc_calc <= '0;
      s_ready  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      mode32_q <= mode32_d;
      pass     <= pass_d;
      err_len  <= err_len_d;
      crc_calc <= crc_calc_d;
      s_ready  <= (state_d == ST_RUN);
      done     <= (state_d == ST_DONE);
    end
  end

  // Next-state and next-value logic for the frame FSM.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mode32_d   = mode32_q;
    pass_d     = pass;
    err_len_d  = err_len;
    crc_calc_d = crc_calc;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode32_d   = (select == SEL_CRC32);
          len_d      = len;
          crc_d      = (select == SEL_CRC32) ? init : {16'h0000, init[CRC16_W-1:0]};
          cnt_d      = '0;
          pass_d     = 1'b0;
          err_len_d  = 1'b0;
          crc_calc_d = '0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (hs_c) begin
          if (!crc_beat_c) begin
            if (s_last) begin
              // Frame ended before the CRC word; the word is not folded in.
              err_len_d = 1'b1;
              pass_d    = 1'b0;
              state_d   = ST_DONE;
            end else begin
              crc_d = crc_step(mode32_q, crc_q, s_data);
              cnt_d = cnt_q + LEN_W'(1);
            end
          end else begin
            // CRC word: report the computed value and stop accepting regardless of s_last.
            crc_calc_d = crc_masked_c;
            pass_d     = s_last && match_c;
            err_len_d  = !s_last;
            state_d    = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crc_stream_checker.sv
// Scoreboard bench for crc_stream_checker: each frame pushes its expected result when driven,
// and the done monitor pops and compares it.
module tb_crc_stream_checker;

  localparam int unsigned LEN_W = 16;
  localparam logic [31:0] P32 = 32'h04C1_1DB7;
  localparam logic [15:0] P16 = 16'h8005;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      init;
  logic [3:0]       select;
  logic [LEN_W-1:0] len;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             done;
  logic             pass;
  logic             err_len;
  logic [31:0]      crc_calc;

  typedef struct {
    logic        pass;
    logic        err;
    logic [31:0] crc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        e;
  logic [31:0] tx_data[$];
  logic        tx_last[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] golden;
  logic [31:0] calc;

  crc_stream_checker #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .init     (init),
    .select   (select),
    .len      (len),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .done     (done),
    .pass     (pass),
    .err_len  (err_len),
    .crc_calc (crc_calc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: shift data bits in MSB-first, feedback = crc MSB ^ data bit.
  function automatic logic [31:0] model_step(input bit m32, input logic [31:0] s,
                                             input logic [31:0] d);
    logic [31:0] c;
    logic [15:0] h;
    logic        fb;
    if (m32) begin
      c = s;
      for (int i = 31; i >= 0; i--) begin
        fb = c[31] ^ d[i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ P32;
      end
      return c;
    end
    h = s[15:0];
    for (int i = 15; i >= 0; i--) begin
      fb = h[15] ^ d[i];
      h  = {h[14:0], 1'b0};
      if (fb) h = h ^ P16;
    end
    return {16'h0000, h};
  endfunction

  function automatic logic [31:0] model_fold(input bit m32, input logic [31:0] ini, input int n);
    logic [31:0] c;
    c = m32 ? ini : {16'h0000, ini[15:0]};
    for (int i = 0; i < n; i++) c = model_step(m32, c, tx_data[i]);
    return c;
  endfunction

  // Result monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("pass", {31'd0, pass}, {31'd0, mon_e.pass});
        chk("err_len", {31'd0, err_len}, {31'd0, mon_e.err});
        chk("crc_calc", crc_calc, mon_e.crc);
      end
    end
  end

  // Drives start then the first nwords of tx_data; optional random gaps carry ignored starts.
  task automatic drive_frame(input logic [3:0] sel, input logic [31:0] ini,
                             input logic [LEN_W-1:0] ln, input int gap_pct, input int nwords);
    int waited;
    @(posedge clk); #1;
    start = 1'b1; select = sel; init = ini; len = ln;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        start   = 1'b1;
        init    = $urandom;
        @(posedge clk); #1;
        start   = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = tx_data[i];
      s_last  = tx_last[i];
      waited  = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        waited++;
        if (waited > 50) break;
      end
      if (waited > 50) begin
        chk("hs_timeout", 32'd1, 32'd0);
        #1; s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    if (nwords == tx_data.size()) begin
      @(negedge clk);
      chk("done_rise", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("done_1cyc", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic load_case1();
    tx_data = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF};
    golden  = model_fold(1'b1, 32'hFFFF_FFFF, 3);
    tx_data.push_back(golden);
    tx_last = '{1'b0, 1'b0, 1'b0, 1'b1};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; init = '0; select = '0; len = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #23;
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {31'd0, err_len}, 32'd0);
    chk("rst_crc", crc_calc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, s_ready}, 32'd0);

    // Case 1: CRC-32 golden frame.
    load_case1();
    e = '{pass: 1'b1, err: 1'b0, crc: golden};
    sb.push_back(e);
    drive_frame(4'hF, 32'hFFFF_FFFF, 16'd3, 0, 4);

    // Case 2: corrupted payload bit, golden CRC word.
    tx_data[1] = tx_data[1] ^ 32'h1;
    calc = model_fold(1'b1, 32'hFFFF_FFFF, 3);
    e = '{pass: 1'b0, err: 1'b0, crc: calc};
    sb.push_back(e);
    drive_frame(4'hF, 32'hFFFF_FFFF, 16'd3, 0, 4);
    chk("crc_ne_golden", {31'd0, crc_calc != golden}, 32'd1);

    // Case 3: CRC-16 with garbage in the upper half of every word.
    tx_data = '{32'h1111_ABCD, 32'h2222_3344};
    calc = model_fold(1'b0, 32'h0000_FFFF, 2);
    tx_data.push_back({16'hABCD, calc[15:0]});
    tx_last = '{1'b0, 1'b0, 1'b1};
    e = '{pass: 1'b1, err: 1'b0, crc: {16'h0000, calc[15:0]}};
    sb.push_back(e);
    drive_frame(4'h0, 32'h0000_FFFF, 16'd2, 0, 3);
    chk("crc16_upper", {16'h0000, crc_calc[31:16]}, 32'd0);

    // Case 4: zero-length payload compared directly against the seed.
    tx_data = '{32'h0000_0000};
    tx_last = '{1'b1};
    e = '{pass: 1'b1, err: 1'b0, crc: 32'h0};
    sb.push_back(e);
    drive_frame(4'hF, 32'h0, 16'd0, 0, 1);

    // Case 5a: s_last on payload beat 1 of a 4-word frame.
    tx_data = '{32'hCAFE_0000, 32'hCAFE_0001};
    tx_last = '{1'b0, 1'b1};
    e = '{pass: 1'b0, err: 1'b1, crc: 32'h0};
    sb.push_back(e);
    drive_frame(4'hF, 32'hFFFF_FFFF, 16'd4, 0, 2);
    chk("rdy_after_early", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    chk("rdy_after_early2", {31'd0, s_ready}, 32'd0);

    // Case 5b: correct CRC word but s_last missing on it.
    tx_data = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
    calc = model_fold(1'b1, 32'h1234_5678, 4);
    tx_data.push_back(calc);
    tx_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{pass: 1'b0, err: 1'b1, crc: calc};
    sb.push_back(e);
    drive_frame(4'hF, 32'h1234_5678, 16'd4, 0, 5);

    // Case 6: case 1 with random valid gaps and ignored start pulses.
    load_case1();
    e = '{pass: 1'b1, err: 1'b0, crc: golden};
    sb.push_back(e);
    drive_frame(4'hF, 32'hFFFF_FFFF, 16'd3, 40, 4);

    // Reset mid-RUN discards the partial frame.
    load_case1();
    drive_frame(4'hF, 32'hFFFF_FFFF, 16'd3, 0, 2);
    chk("midrun_ready", {31'd0, s_ready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, s_ready}, 32'd0);

    // Fresh start reproduces case 1, then reset drops held pass asynchronously.
    e = '{pass: 1'b1, err: 1'b0, crc: golden};
    sb.push_back(e);
    drive_frame(4'hF, 32'hFFFF_FFFF, 16'd3, 0, 4);
    repeat (2) @(negedge clk);
    chk("pass_held", {31'd0, pass}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_crc", crc_calc, 32'd0);
    chk("arst_err", {31'd0, err_len}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
